fetch_unit: RTL and testbench

- Instruction fetch sequencer: holds the program counter and reads instruction words (plus a jump-target word for two-word jumps) from program memory over a req/ready handshake.
- Presents instruction, peek word and sequential fall-through address to decision_unit and the execute stage.
- Loads the decision unit's resolved next address into the PC when execute consumes the instruction.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads one or two program words per
// instruction over a req/ready handshake and hands them to decision/execute.
module fetch_unit #(
  parameter int unsigned          WORD_SIZE    = 16,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [7:0]           HALT_OPCODE  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] peek_word,
  output logic [WORD_SIZE-1:0] seq_address,
  output logic                 fetch_valid,
  input  logic                 advance,
  input  logic [WORD_SIZE-1:0] next_address,
  output logic                 halted
);

  localparam logic [WORD_SIZE-1:0] ONE_W      = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] TWO_W      = {{(WORD_SIZE-2){1'b0}}, 2'b10};
  localparam logic [WORD_SIZE-1:0] ZERO_W     = {WORD_SIZE{1'b0}};
  localparam logic [WORD_SIZE-1:0] SEQ_RESET  = RESET_VECTOR + ONE_W;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH_INSTR = 3'd1,
    ST_FETCH_PEEK  = 3'd2,
    ST_VALID       = 3'd3,
    ST_HALTED      = 3'd4
  } state_t;

  // Opcodes JMP..JLE carry their target in the following word.
  function automatic logic is_two_word(input logic [7:0] opcode);
    is_two_word = (opcode >= 8'h14) && (opcode <= 8'h24);
  endfunction

  state_t               state_r, state_s;
  logic [WORD_SIZE-1:0] pc_r, pc_s;
  logic [WORD_SIZE-1:0] mem_addr_r, mem_addr_s;
  logic                 mem_req_r, mem_req_s;
  logic [WORD_SIZE-1:0] instr_r, instr_s;
  logic [WORD_SIZE-1:0] peek_r, peek_s;
  logic [WORD_SIZE-1:0] seq_r, seq_s;
  logic                 valid_r, valid_s;
  logic                 halted_r, halted_s;
  logic [WORD_SIZE-1:0] pc_inc1_s, pc_inc2_s;

  assign pc_inc1_s = pc_r + ONE_W;
  assign pc_inc2_s = pc_r + TWO_W;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    mem_addr_s = mem_addr_r;
    mem_req_s  = 1'b0;
    instr_s    = instr_r;
    peek_s     = peek_r;
    seq_s      = seq_r;
    valid_s    = 1'b0;
    halted_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s    = ST_FETCH_INSTR;
        mem_req_s  = 1'b1;
        mem_addr_s = pc_r;
      end
      ST_FETCH_INSTR: begin
        if (mem_ready) begin
          instr_s = mem_rdata;
          if (is_two_word(mem_rdata[WORD_SIZE-1 -: 8])) begin
            state_s    = ST_FETCH_PEEK;
            mem_req_s  = 1'b1;
            mem_addr_s = pc_inc1_s;
          end else begin
            state_s = ST_VALID;
            peek_s  = ZERO_W;
            seq_s   = pc_inc1_s;
            valid_s = 1'b1;
          end
        end else begin
          mem_req_s = 1'b1;
        end
      end
      ST_FETCH_PEEK: begin
        if (mem_ready) begin
          state_s = ST_VALID;
          peek_s  = mem_rdata;
          seq_s   = pc_inc2_s;
          valid_s = 1'b1;
        end else begin
          mem_req_s = 1'b1;
        end
      end
      ST_VALID: begin
        if (advance) begin
          if (instr_r[WORD_SIZE-1 -: 8] == HALT_OPCODE) begin
            state_s  = ST_HALTED;
            halted_s = 1'b1;
          end else begin
            state_s    = ST_FETCH_INSTR;
            pc_s       = next_address;
            mem_addr_s = next_address;
            mem_req_s  = 1'b1;
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_VECTOR;
      mem_addr_r <= RESET_VECTOR;
      mem_req_r  <= 1'b0;
      instr_r    <= ZERO_W;
      peek_r     <= ZERO_W;
      seq_r      <= SEQ_RESET;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      mem_addr_r <= mem_addr_s;
      mem_req_r  <= mem_req_s;
      instr_r    <= instr_s;
      peek_r     <= peek_s;
      seq_r      <= seq_s;
      valid_r    <= valid_s;
      halted_r   <= halted_s;
    end
  end

  assign mem_addr    = mem_addr_r;
  assign mem_req     = mem_req_r;
  assign pc          = pc_r;
  assign instruction = instr_r;
  assign peek_word   = peek_r;
  assign seq_address = seq_r;
  assign fetch_valid = valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases plus randomized
// instruction streams checked against a per-instruction reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [15:0] peek_word;
  logic [15:0] seq_address;
  logic        fetch_valid;
  logic        advance;
  logic [15:0] next_address;
  logic        halted;

  int total = 0;
  int bad   = 0;

  bit [15:0]   mem [0:65535];
  logic [15:0] m_pc;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .peek_word    (peek_word),
    .seq_address  (seq_address),
    .fetch_valid  (fetch_valid),
    .advance      (advance),
    .next_address (next_address),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk16("rst_pc", pc, 16'h0000);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_instruction", instruction, 16'h0000);
    chk16("rst_peek", peek_word, 16'h0000);
    chk16("rst_seq", seq_address, 16'h0001);
    chk1("rst_fetch_valid", fetch_valid, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_halted", halted, 1'b0);
  endtask

  // Assert reset (effect must be immediate), release it, let the idle cycle pass.
  task automatic do_reset();
    rst_n   = 1'b0;
    advance = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clk);
    chk_reset_values();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    tick();
    m_pc = 16'h0000;
  endtask

  // One memory word: `waits` stall cycles, then a one-cycle completion.
  task automatic read_word(input string tag, input logic [15:0] addr, input int waits);
    for (int w = 0; w < waits; w++) begin
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      chk1({tag, "_req_wait"}, mem_req, 1'b1);
      chk16({tag, "_addr_wait"}, mem_addr, addr);
      chk1({tag, "_valid_wait"}, fetch_valid, 1'b0);
      tick();
    end
    chk1({tag, "_req"}, mem_req, 1'b1);
    chk16({tag, "_addr"}, mem_addr, addr);
    chk16({tag, "_pc"}, pc, m_pc);
    mem_ready = 1'b1;
    mem_rdata = mem[addr];
    tick();
    mem_ready = 1'($urandom);
    mem_rdata = 16'($urandom);
  endtask

  // Full life of the instruction at m_pc: reads, presentation, hold, advance.
  task automatic run_instr(input logic [15:0] nxt, input int w_i, input int w_p, input int hold);
    logic [15:0] a1, iw, pw, sq;
    logic        two;
    iw  = mem[m_pc];
    two = (iw[15:8] >= 8'h14) && (iw[15:8] <= 8'h24);
    a1  = m_pc + 16'd1;
    pw  = two ? mem[a1] : 16'h0000;
    sq  = m_pc + (two ? 16'd2 : 16'd1);
    read_word("rd_instr", m_pc, w_i);
    if (two) read_word("rd_peek", a1, w_p);
    for (int h = 0; h <= hold; h++) begin
      chk1("valid", fetch_valid, 1'b1);
      chk16("instruction", instruction, iw);
      chk16("peek_word", peek_word, pw);
      chk16("seq_address", seq_address, sq);
      chk16("pc_valid", pc, m_pc);
      chk1("req_in_valid", mem_req, 1'b0);
      chk1("halted_in_valid", halted, 1'b0);
      if (h < hold) begin
        mem_ready    = 1'($urandom);
        next_address = 16'($urandom);
        tick();
      end
    end
    advance      = 1'b1;
    next_address = nxt;
    tick();
    advance      = 1'b0;
    next_address = 16'($urandom);
    chk1("valid_after_adv", fetch_valid, 1'b0);
    if (iw[15:8] == 8'hFF) begin
      chk1("halted_set", halted, 1'b1);
      chk1("halt_req", mem_req, 1'b0);
    end else begin
      chk1("adv_req", mem_req, 1'b1);
      chk16("adv_addr", mem_addr, nxt);
      chk16("adv_pc", pc, nxt);
      chk1("adv_halted", halted, 1'b0);
      m_pc = nxt;
    end
  endtask

  // Random program word that is never a halt.
  task automatic fill_random(input logic [15:0] addr);
    logic [15:0] w;
    logic [15:0] a1;
    w = 16'($urandom);
    if ($urandom_range(0, 1) == 0) w[15:8] = 8'(8'h14 + $urandom_range(0, 16));
    if (w[15:8] == 8'hFF) w[15:8] = 8'h01;
    a1 = addr + 16'd1;
    mem[addr] = w;
    mem[a1]   = 16'($urandom);
  endtask

  initial begin
    logic [15:0] nxt;
    rst_n        = 1'b1;
    advance      = 1'b0;
    mem_ready    = 1'b1;
    mem_rdata    = 16'h0000;
    next_address = 16'h0000;
    m_pc         = 16'h0000;

    mem[16'h0000] = 16'h0102;
    mem[16'h0001] = 16'h0300;
    mem[16'h0004] = 16'h1400;
    mem[16'h0005] = 16'h0040;
    mem[16'h0040] = 16'h1500;
    mem[16'h0041] = 16'h1234;
    mem[16'hFFFF] = 16'h1500;
    mem[16'hFFFE] = 16'h1600;

    #2;
    do_reset();

    run_instr(16'h0001, 0, 0, 0);
    run_instr(16'h0004, 0, 0, 0);
    run_instr(16'h0040, 0, 0, 5);
    run_instr(16'hFFFF, 1, 3, 0);
    run_instr(16'hFFFE, 0, 0, 0);
    run_instr(16'hFFFE, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      nxt = ($urandom_range(0, 7) == 0) ? m_pc : 16'($urandom);
      run_instr(nxt, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      fill_random(nxt);
    end

    mem[m_pc] = 16'hFF00;
    run_instr(16'h1234, 0, 0, 2);
    for (int k = 0; k < 4; k++) begin
      advance      = 1'b1;
      mem_ready    = 1'b1;
      next_address = 16'($urandom);
      tick();
      chk1("halt_stays", halted, 1'b1);
      chk1("halt_no_req", mem_req, 1'b0);
      chk1("halt_no_valid", fetch_valid, 1'b0);
    end
    advance = 1'b0;

    mem[16'h0000] = 16'h1400;
    mem[16'h0001] = 16'hABCD;
    do_reset();
    read_word("rd_instr_pre", 16'h0000, 0);
    chk1("mid_peek_req", mem_req, 1'b1);
    chk16("mid_peek_addr", mem_addr, 16'h0001);
    mem_ready = 1'b0;
    do_reset();
    run_instr(16'h0002, 0, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
